// File: rtl/display_bcd_8bits.sv
// rtl/display_bcd_8bits.sv - binary to 3-digit BCD converter with multiplexed 7-segment scanner
module display_bcd_8bits #(
   parameter int WIDTH    = 8,
   parameter int SCAN_DIV = 50000,
   parameter int BLANK_LZ = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] value,
   output logic [11:0]      bcd,
   output logic             valid,
   output logic [6:0]       seg,
   output logic [2:0]       an
);

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_SHIFT  = 2'd1,
      S_UPDATE = 2'd2
   } state_t;

   localparam int CW = $clog2(WIDTH + 1);
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // converter state
   state_t           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [11:0]      scratch_q;
   logic [CW-1:0]    cnt_q;
   logic [11:0]      bcd_q;
   logic             valid_q;
   logic [11:0]      adj_d;

   // scanner state
   logic [DW-1:0]    div_q;
   logic [1:0]       idx_q;
   logic [2:0]       an_q;
   logic [6:0]       seg_q;
   logic [3:0]       digit_d;
   logic             blank_d;
   logic [6:0]       seg_d;
   logic [2:0]       an_d;
   logic             wrap_d;

   // active-low segment pattern {g,f,e,d,c,b,a}; nibbles above 9 show nothing
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // add-3 correction of every scratch nibble that is 5 or more before the next shift
   always_comb begin
      adj_d = scratch_q;
      for (int i = 0; i < 3; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // double-dabble sequencer: load, WIDTH shifts, publish result, repeat
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_LOAD;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_LOAD: begin
               shift_q   <= value;
               scratch_q <= '0;
               cnt_q     <= CW'(WIDTH);
               state_q   <= S_SHIFT;
            end
            S_SHIFT: begin
               scratch_q <= {adj_d[10:0], shift_q[WIDTH-1]};
               shift_q   <= shift_q << 1;
               cnt_q     <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               bcd_q   <= scratch_q;
               valid_q <= 1'b1;
               state_q <= S_LOAD;
            end
            default: begin
               state_q <= S_LOAD;
            end
         endcase
      end
   end

   // pick the digit for the current scan slot and apply leading-zero blanking
   always_comb begin
      wrap_d = (div_q == DW'(SCAN_DIV - 1));
      case (idx_q)
         2'd0: begin
            digit_d = bcd_q[3:0];
            an_d    = 3'b110;
         end
         2'd1: begin
            digit_d = bcd_q[7:4];
            an_d    = 3'b101;
         end
         default: begin
            digit_d = bcd_q[11:8];
            an_d    = 3'b011;
         end
      endcase
      blank_d = 1'b0;
      if (BLANK_LZ != 0) begin
         if (idx_q == 2'd2 && bcd_q[11:8] == 4'd0) begin
            blank_d = 1'b1;
         end
         if (idx_q == 2'd1 && bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) begin
            blank_d = 1'b1;
         end
      end
      seg_d = blank_d ? SEG_BLANK : seg_decode(digit_d);
   end

   // scan divider, digit index and registered pin drivers
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_q <= '0;
         idx_q <= 2'd0;
         an_q  <= 3'b111;
         seg_q <= SEG_BLANK;
      end else begin
         if (wrap_d) begin
            div_q <= '0;
            idx_q <= (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
         end else begin
            div_q <= div_q + DW'(1);
         end
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign bcd   = bcd_q;
   assign valid = valid_q;
   assign seg   = seg_q;
   assign an    = an_q;

endmodule

// File: tb/tb_display_bcd_8bits.sv
// tb/tb_display_bcd_8bits.sv - randomized self-checking bench for display_bcd_8bits
module tb_display_bcd_8bits;

   logic       clk;
   logic       rst;
   logic [7:0] value;
   logic [11:0] bcd, bcd_nb;
   logic       valid, valid_nb;
   logic [6:0] seg, seg_nb;
   logic [2:0] an, an_nb;

   int n_cmp;
   int n_bad;

   // model state
   int         k;
   int         cap;
   logic [11:0] exp_bcd;
   logic       exp_valid;
   logic [2:0] exp_an;
   logic [6:0] exp_seg;
   logic [6:0] exp_seg_nb;
   logic [6:0] seg_tab [10];

   display_bcd_8bits #(.WIDTH(8), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
      .clk   (clk),
      .rst   (rst),
      .value (value),
      .bcd   (bcd),
      .valid (valid),
      .seg   (seg),
      .an    (an)
   );

   display_bcd_8bits #(.WIDTH(8), .SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
      .clk   (clk),
      .rst   (rst),
      .value (value),
      .bcd   (bcd_nb),
      .valid (valid_nb),
      .seg   (seg_nb),
      .an    (an_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle k=%0d)", tag, got, exp, k);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // what the display shows for a number in a given slot (0 units, 1 tens, 2 hundreds)
   function automatic logic [6:0] show(input logic [11:0] b, input int slot, input bit blank_lz);
      int h, t, u;
      h = int'(b[11:8]);
      t = int'(b[7:4]);
      u = int'(b[3:0]);
      if (slot == 0) return seg_tab[u];
      if (slot == 1) return (blank_lz && h == 0 && t == 0) ? 7'h7F : seg_tab[t];
      return (blank_lz && h == 0) ? 7'h7F : seg_tab[h];
   endfunction

   // apply inputs for one edge, advance the model, compare after the edge
   task automatic step(input logic r, input logic [7:0] v);
      int slot;
      rst   = r;
      value = v;
      @(posedge clk);
      #1;
      if (!r) begin
         k          = 0;
         exp_bcd    = 12'h000;
         exp_valid  = 1'b0;
         exp_an     = 3'b111;
         exp_seg    = 7'h7F;
         exp_seg_nb = 7'h7F;
      end else begin
         k++;
         if ((k - 1) % 10 == 0) cap = int'(v);
         slot       = ((k - 1) / 4) % 3;
         exp_an     = ~(3'b001 << slot);
         exp_seg    = show(exp_bcd, slot, 1'b1);
         exp_seg_nb = show(exp_bcd, slot, 1'b0);
         if (k % 10 == 0) begin
            exp_bcd   = to_bcd(cap);
            exp_valid = 1'b1;
         end else begin
            exp_valid = 1'b0;
         end
      end
      chk("valid", 32'(valid), 32'(exp_valid));
      chk("bcd", 32'(bcd), 32'(exp_bcd));
      chk("an", 32'(an), 32'(exp_an));
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("seg_nolz", 32'(seg_nb), 32'(exp_seg_nb));
      chk("bcd_nolz", 32'(bcd_nb), 32'(exp_bcd));
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] ctr;
      n_cmp = 0;
      n_bad = 0;
      k     = 0;
      cap   = 0;
      seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
      seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
      seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
      rst   = 1'b0;
      value = 8'd0;

      // reset with a nonzero value waiting
      for (int i = 0; i < 3; i++) step(1'b0, 8'd123);
      chk("rst_an", 32'(an), 32'h7);
      chk("rst_seg", 32'(seg), 32'h7F);
      step(1'b1, 8'd123);
      chk("rel_an", 32'(an), 32'h6);
      chk("rel_seg", 32'(seg), 32'h40);
      for (int i = 0; i < 29; i++) step(1'b1, 8'd123);

      // full scale, then leading-zero cases
      for (int i = 0; i < 40; i++) step(1'b1, 8'd255);
      chk("full_bcd", 32'(bcd), 32'h255);
      for (int i = 0; i < 40; i++) step(1'b1, 8'd7);
      chk("seven_bcd", 32'(bcd), 32'h007);
      for (int i = 0; i < 40; i++) step(1'b1, 8'd100);
      chk("hundred_bcd", 32'(bcd), 32'h100);

      // value changes during SHIFT: held until next LOAD
      for (int i = 0; i < 40; i++) step(1'b1, (k % 10 >= 3 && k % 10 <= 6) ? 8'd200 : 8'd10);

      // counter stream with wrap
      ctr = 8'd240;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, ctr);
         ctr = ctr + 8'd1;
      end

      // random values, random hold lengths
      for (int i = 0; i < 40; i++) begin
         v = 8'($urandom_range(0, 255));
         for (int j = 0; j < int'($urandom_range(1, 14)); j++) step(1'b1, v);
      end

      // reset during the 5th SHIFT edge of a period
      while (k % 10 != 5) step(1'b1, 8'd99);
      step(1'b0, 8'd99);
      chk("midrst_valid", 32'(valid), 32'h0);
      chk("midrst_bcd", 32'(bcd), 32'h000);
      chk("midrst_an", 32'(an), 32'h7);
      step(1'b1, 8'd42);
      chk("restart_an", 32'(an), 32'h6);
      chk("restart_seg", 32'(seg), 32'h40);
      for (int i = 0; i < 40; i++) step(1'b1, 8'd42);
      chk("restart_bcd", 32'(bcd), 32'h042);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
